// File: rtl/matrix_feed_controller.sv
// matrix_feed_controller
//   Front end for the 3x3 determinant unit. Collects nine unsigned 8-bit
//   elements (row-major) from a valid/ready byte stream into a 16x8 buffer,
//   pulses the determinant unit's start, waits for its done, and holds the
//   16-bit determinant until a downstream consumer takes it.
//
//   Ports
//     clock, reset        single clock, synchronous active-high reset
//     in_valid/in_data    upstream byte stream
//     in_ready            byte accepted this cycle when in_valid & in_ready
//     det_adress          determinant unit read address
//     det_data            buffer word at det_adress (combinational)
//     det_start           one-cycle start pulse
//     det_start_adress    buffer address of element a00
//     det_done/det_result determinant unit completion and value
//     result/result_valid captured determinant, valid until consumed
//     result_ready        downstream accepts result
//     busy                high whenever the block is not loading
//
//   state | meaning
//   ------+----------------------------------------------------------
//   LOAD  | accepting bytes into the buffer
//   START | single-cycle start pulse to the determinant unit
//   WAIT  | waiting for det_done; captures det_result on it
//   OUT   | result held until result_ready

module matrix_feed_controller #(
  parameter int          ELEMS      = 9,
  parameter logic [3:0]  START_ADDR = 4'd0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  input  logic [3:0]  det_adress,
  output logic [7:0]  det_data,
  output logic        det_start,
  output logic [3:0]  det_start_adress,
  input  logic        det_done,
  input  logic [15:0] det_result,
  output logic [15:0] result,
  output logic        result_valid,
  input  logic        result_ready,
  output logic        busy
);

  typedef enum logic [1:0] {S_LOAD, S_START, S_WAIT, S_OUT} state_t;

  localparam logic [3:0] LAST_ADDR = START_ADDR + 4'(ELEMS - 1);

  state_t      state, state_next;
  logic [7:0]  mem [16];
  logic [3:0]  wptr;
  logic        accept;
  logic        capture;
  logic        consume;

  assign accept           = in_valid & in_ready;
  assign capture          = (state == S_WAIT) & det_done;
  assign consume          = (state == S_OUT) & result_ready;
  assign det_data         = mem[det_adress];
  assign det_start_adress = START_ADDR;

  always_ff @(posedge clock) begin
    if (reset) state <= S_LOAD;
    else       state <= state_next;
  end

  always_comb begin
    state_next   = state;
    in_ready     = 1'b0;
    det_start    = 1'b0;
    result_valid = 1'b0;
    busy         = 1'b1;
    case (state)
      S_LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        // the accept of the last element ends the load phase
        if (in_valid && (wptr == LAST_ADDR)) state_next = S_START;
      end
      S_START: begin
        det_start  = 1'b1;
        state_next = S_WAIT;
      end
      S_WAIT: begin
        if (det_done) state_next = S_OUT;
      end
      S_OUT: begin
        result_valid = 1'b1;
        if (result_ready) state_next = S_LOAD;
      end
      default: state_next = S_LOAD;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wptr   <= START_ADDR;
      result <= '0;
      for (int i = 0; i < 16; i++) mem[i] <= '0;
    end else begin
      if (accept) begin
        mem[wptr] <= in_data;
        wptr      <= wptr + 4'd1;
      end
      if (capture) result <= det_result;
      if (consume) wptr   <= START_ADDR;
    end
  end

endmodule

// File: tb/tb_matrix_feed_controller.sv
module tb_matrix_feed_controller;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic [3:0]  det_adress;
  logic [7:0]  det_data;
  logic        det_start;
  logic [3:0]  det_start_adress;
  logic        det_done;
  logic [15:0] det_result;
  logic [15:0] result;
  logic        result_valid;
  logic        result_ready;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;
  int start_cnt = 0;

  matrix_feed_controller dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .det_adress(det_adress), .det_data(det_data),
    .det_start(det_start), .det_start_adress(det_start_adress),
    .det_done(det_done), .det_result(det_result), .result(result),
    .result_valid(result_valid), .result_ready(result_ready), .busy(busy)
  );

  always #5 clock = ~clock;

  always @(posedge clock) if (det_start) start_cnt++;

  typedef struct {
    logic [7:0]  b [9];
    bit          gapped;
    logic [15:0] det;
    int          t_det;
  } mat_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    @(negedge clock);
  endtask

  // Streams nine bytes; optional two idle cycles between bytes and an
  // optional stray det_done before byte index spur. Ends at the negedge
  // after the ninth accept.
  task automatic load(input logic [7:0] b [9], input bit gapped, input int spur);
    for (int i = 0; i < 9; i++) begin
      if (gapped && i > 0) begin
        in_valid = 1'b0;
        cyc();
        cyc();
      end
      if (i == spur) begin
        in_valid = 1'b0;
        det_done = 1'b1;
        det_result = 16'hBEEF;
        cyc();
        det_done = 1'b0;
        chk("spur_in_ready", in_ready, 1);
        chk("spur_result_valid", result_valid, 0);
        chk("spur_busy", busy, 0);
      end
      in_valid = 1'b1;
      in_data  = b[i];
      chk($sformatf("load_ready_%0d", i), in_ready, 1);
      chk($sformatf("load_nostart_%0d", i), det_start, 0);
      cyc();
    end
    in_valid = 1'b0;
    in_data  = 8'h00;
  endtask

  // Called right after load: checks the start pulse, sweeps the buffer while
  // the model unit "computes", then returns done with det.
  task automatic compute(input logic [7:0] b [9], input logic [15:0] det,
                         input int t_det, input logic [15:0] prev, input int cnt0);
    chk("start_pulse", det_start, 1);
    chk("start_in_ready", in_ready, 0);
    chk("start_busy", busy, 1);
    cyc();
    for (int c = 0; c < t_det; c++) begin
      if (c < 16) begin
        det_adress = 4'(c);
        #1;
        chk($sformatf("rd_%0d", c), det_data, (c < 9) ? 32'(b[c]) : 32'h0);
      end
      if (c == 0) begin
        chk("wait_start_low", det_start, 0);
        chk("wait_result_held", result, prev);
        chk("wait_rv", result_valid, 0);
      end
      cyc();
    end
    det_done   = 1'b1;
    det_result = det;
    cyc();
    det_done   = 1'b0;
    det_result = 16'h1234;
    chk("out_rv", result_valid, 1);
    chk("out_result", result, det);
    chk("out_busy", busy, 1);
    chk("start_count", start_cnt - cnt0, 1);
  endtask

  task automatic release_out();
    result_ready = 1'b1;
    cyc();
    result_ready = 1'b0;
    chk("rel_in_ready", in_ready, 1);
    chk("rel_rv", result_valid, 0);
    chk("rel_busy", busy, 0);
  endtask

  mat_t mats [3];
  mat_t bp;
  logic [15:0] prev;
  int cnt0;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    mats[0].b = '{8'd1, 8'd0, 8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd1};
    mats[0].gapped = 1'b0; mats[0].det = 16'h0001; mats[0].t_det = 20;
    mats[1].b = '{8'd2, 8'd0, 8'd1, 8'd1, 8'd3, 8'd2, 8'd1, 8'd1, 8'd0};
    mats[1].gapped = 1'b1; mats[1].det = 16'hFFF3; mats[1].t_det = 18;
    mats[2].b = '{8'd5, 8'd6, 8'd7, 8'd8, 8'd9, 8'd10, 8'd11, 8'd12, 8'hFF};
    mats[2].gapped = 1'b0; mats[2].det = 16'h8000; mats[2].t_det = 16;
    bp.b = '{8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    bp.gapped = 1'b0; bp.det = 16'h7FFE; bp.t_det = 16;

    reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; det_adress = 4'd0;
    det_done = 1'b0; det_result = 16'h0; result_ready = 1'b0;
    @(negedge clock);
    cyc();
    reset = 1'b0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_det_start", det_start, 0);
    chk("rst_start_adr", det_start_adress, 0);
    chk("rst_result", result, 0);
    chk("rst_rv", result_valid, 0);
    chk("rst_busy", busy, 0);
    det_adress = 4'd5; #1;
    chk("rst_det_data", det_data, 0);

    // table-driven matrices: identity, gapped, consecutive overwrite
    prev = 16'h0000;
    for (int m = 0; m < 3; m++) begin
      cnt0 = start_cnt;
      load(mats[m].b, mats[m].gapped, -1);
      compute(mats[m].b, mats[m].det, mats[m].t_det, prev, cnt0);
      release_out();
      chk("post_rel_result", result, mats[m].det);
      prev = mats[m].det;
    end

    // backpressure with upstream pushing 8'hAA throughout
    cnt0 = start_cnt;
    load(bp.b, 1'b0, -1);
    compute(bp.b, bp.det, bp.t_det, prev, cnt0);
    in_valid = 1'b1; in_data = 8'hAA; det_adress = 4'd0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_result", result, bp.det);
      chk("bp_rv", result_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_busy", busy, 1);
      chk("bp_buf0", det_data, bp.b[0]);
      cyc();
    end
    result_ready = 1'b1;
    cyc();
    result_ready = 1'b0;
    chk("bp_rel_in_ready", in_ready, 1);
    cyc();
    in_valid = 1'b0;
    det_adress = 4'd0; #1;
    chk("bp_new_buf0", det_data, 8'hAA);
    det_adress = 4'd1; #1;
    chk("bp_old_buf1", det_data, bp.b[1]);

    // reset mid-WAIT
    reset = 1'b1; cyc(); reset = 1'b0;
    load(mats[2].b, 1'b0, -1);
    chk("rw_start", det_start, 1);
    cyc(); cyc(); cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    det_done = 1'b1; det_result = 16'h5555;
    cyc();
    cyc();
    det_done = 1'b0;
    chk("rw_rv", result_valid, 0);
    chk("rw_result", result, 0);
    chk("rw_in_ready", in_ready, 1);
    chk("rw_busy", busy, 0);
    for (int a = 0; a < 9; a += 4) begin
      det_adress = 4'(a); #1;
      chk($sformatf("rw_buf_%0d", a), det_data, 0);
    end

    // spurious done after four bytes during LOAD
    cnt0 = start_cnt;
    load(mats[1].b, 1'b0, 4);
    compute(mats[1].b, 16'h0042, 16, 16'h0000, cnt0);
    release_out();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
